arbiter_rr_n: RTL and testbench
===============================

// Module: arbiter_rr_n
// PURPOSE
//   N-requester bus arbiter: generalises the two-channel req0/req1 -> gnt0/gnt1
//   arbiter to N channels. Run-time selectable fixed-priority or round-robin mode.
//   Bounded grant hold (starvation guard). Registered one-hot grant plus encoded id.
//   Sits between N masters and one shared resource; the driver/checker/scoreboard
//   bench drives req and checks gnt.
// PARAMETERS
//   N        4  number of requesters (2..16)
//   HOLD_MAX 8  max consecutive cycles one owner holds gnt while others wait; 0 = unlimited
//   ID_W     2  width of gnt_id, must equal clog2(N)
// PORTS
//   clk        input   1     rising-edge clock
//   reset      input   1     asynchronous, active-high reset
//   req        input   N     request per channel, level-sensitive, bit i = channel i
//   mode       input   1     0 = fixed priority (lowest index wins), 1 = round-robin
//   gnt        output  N     registered one-hot grant; all zero when idle
//   gnt_valid  output  1     registered; 1 iff gnt != 0
//   gnt_id     output  ID_W  registered index of granted channel; 0 when idle
//   hold_cnt   output  8     cycles current owner has held gnt, saturating at 255
// BEHAVIOUR
// - Reset (async, any time incl. mid-grant): gnt=0, gnt_valid=0, gnt_id=0,
//   hold_cnt=0, rr pointer=0, state=IDLE. Outputs drop immediately, not at next edge.
// - States:
//   - IDLE: no owner.
//   - GRANT: owner = gnt_id.
// - Latency: req sampled at posedge k -> gnt valid after posedge k (1 cycle, registered).
// - Arbitration point, evaluated at a posedge:
//   (a) state IDLE and req!=0;
//   (b) GRANT and req[owner]==0;
//   (c) GRANT, HOLD_MAX!=0, hold_cnt==HOLD_MAX-1, and (req & ~gnt)!=0.
//   Mode is sampled only at arbitration points; no mid-grant switch.
// - Winner selection:
//   - Fixed: lowest index i with req[i]=1.
//   - Round-robin: first req[i]=1 searching ptr, ptr+1, ..., wrapping mod N.
//   - After any grant to i, ptr <= (i+1) mod N. ptr is updated in both modes.
//   - Case (c): owner is excluded from the candidate set in both modes.
// - Transitions:
//   - IDLE -> GRANT on (a).
//   - GRANT -> GRANT (new owner, no idle bubble) on (b) or (c) when a candidate exists.
//   - GRANT -> IDLE on (b) with req==0. gnt=0 the next cycle.
// - hold_cnt:
//   - 0 on a new grant; +1 each cycle the owner is retained; saturates at 255.
//   - HOLD_MAX reached with no other requester: owner keeps gnt, hold_cnt keeps
//     counting. Forced release occurs on the first cycle another req appears.
// - Invariants: gnt is one-hot or zero, never multi-hot. gnt_id == index of set bit.
//   gnt_valid == |gnt.
// - Simultaneous events:
//   - Owner drops req in the same cycle HOLD_MAX expires: treated as (b), owner
//     not re-eligible anyway.
//   - Req asserting on the release edge is eligible in that arbitration.
// - A requester dropping req before being granted is simply not considered.
//   No request latching.
// TESTING (N=4, HOLD_MAX=4)
// 1. Reset mid-grant: gnt=4'b0010, assert reset between edges -> gnt=0, gnt_id=0,
//    hold_cnt=0 immediately. After release, req=4'b0100 -> gnt=4'b0100 next edge.
// 2. Fixed mode: mode=0, req=4'b1110 held, owners drop req after 2 cycles each
//    -> grant order 1,2,3. Back-to-back, no idle cycle between grants.
// 3. Round-robin: mode=1, req=4'b1111 held constant -> grants rotate 0,1,2,3,0.
//    Each held 4 cycles by HOLD_MAX forced release; hold_cnt goes 0..3 per owner.
// 4. Starvation guard: mode=0, req=4'b0011 held -> ch0 for 4 cycles, then ch1
//    for 4, then ch0. Lone req=4'b0001 held 20 cycles -> gnt stays 4'b0001,
//    hold_cnt reaches 19.
// 5. Idle/empty: req drops to 0 -> gnt=0, gnt_valid=0 next edge. Mode toggled
//    mid-grant -> no change until the next arbitration point.
// 6. Random 100-iteration req/mode stress; checker asserts one-hot and
//    gnt_id/gnt_valid consistency. Scoreboard confirms no channel with continuous
//    req waits > (N-1)*HOLD_MAX cycles in round-robin mode.

Source files
------------

// File: rtl/arbiter_rr_n.sv
// N-requester arbiter, fixed-priority or round-robin, with a bounded grant hold.
// Latency: req sampled at a posedge, grant registered on that same edge (1 cycle).
// Backpressure: none; req is level-sensitive and is not latched, so a requester
//   that drops req before being granted is ignored.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset; outputs clear at once
//   req       per-channel request, bit i = channel i
//   mode      0 = fixed priority (lowest index wins), 1 = round-robin
//   gnt       registered one-hot grant, zero when idle
//   gnt_valid high iff gnt != 0
//   gnt_id    index of the granted channel, 0 when idle
//   hold_cnt  cycles the current owner has held gnt, saturating at 255
module arbiter_rr_n #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 8,
    parameter int ID_W     = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic            mode,
    output logic [N-1:0]    gnt,
    output logic            gnt_valid,
    output logic [ID_W-1:0] gnt_id,
    output logic [7:0]      hold_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam bit              HOLD_EN   = (HOLD_MAX != 0);
    localparam logic [7:0]      HOLD_LAST = HOLD_EN ? 8'(HOLD_MAX - 1) : 8'd0;
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(N - 1);
    localparam logic [ID_W:0]   N_W       = (ID_W + 1)'(N);

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [7:0]      hold_q, hold_d;
    logic [ID_W-1:0] ptr_q, ptr_d;

    logic            arb_a, arb_b, arb_c;
    logic [N-1:0]    others;
    logic [N-1:0]    cand;
    logic [ID_W-1:0] start;
    logic            found;
    logic [ID_W-1:0] win;

    always_comb begin : p_next
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] idx;

        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        hold_d  = hold_q;
        ptr_d   = ptr_q;
        sum     = '0;
        idx     = '0;
        found   = 1'b0;
        win     = '0;

        others = req & ~gnt_q;
        arb_a  = (state_q == IDLE) && (|req);
        arb_b  = (state_q == GRANT) && !req[id_q];
        // Hold limit uses >= so that an owner kept past the limit (nobody else
        // waiting) is released on the first cycle another request shows up.
        arb_c  = (state_q == GRANT) && req[id_q] && HOLD_EN &&
                 (hold_q >= HOLD_LAST) && (|others);

        // A forced release excludes the current owner; a voluntary drop
        // already has the owner's bit clear in req.
        cand  = arb_c ? others : req;
        start = mode ? ptr_q : '0;

        // Circular search from start; fixed priority is the search from 0.
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, start} + (ID_W + 1)'(i);
            if (sum >= N_W) begin
                sum = sum - N_W;
            end
            idx = sum[ID_W-1:0];
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end

        if (arb_a || arb_b || arb_c) begin
            if (found) begin
                state_d = GRANT;
                gnt_d   = N'(1) << win;
                id_d    = win;
                hold_d  = 8'd0;
                ptr_d   = (win == LAST_ID) ? '0 : win + 1'b1;
            end else begin
                state_d = IDLE;
                gnt_d   = '0;
                id_d    = '0;
                hold_d  = 8'd0;
            end
        end else if ((state_q == GRANT) && (hold_q != 8'hFF)) begin
            hold_d = hold_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            hold_q  <= 8'd0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            hold_q  <= hold_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = id_q;
    assign hold_cnt  = hold_q;

endmodule

// File: tb/tb_arbiter_rr_n.sv
// Bench for arbiter_rr_n with N=4, HOLD_MAX=4.
// Latency: expectations are compared 1 ns after the edge that samples req.
// Backpressure: none; stimulus is driven on the falling edge.
module tb_arbiter_rr_n;

    localparam int N        = 4;
    localparam int HOLD_MAX = 4;
    localparam int ID_W     = 2;
    localparam int WAIT_MAX = (N - 1) * HOLD_MAX;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req;
    logic            mode;
    logic [N-1:0]    gnt;
    logic            gnt_valid;
    logic [ID_W-1:0] gnt_id;
    logic [7:0]      hold_cnt;

    arbiter_rr_n #(.N(N), .HOLD_MAX(HOLD_MAX), .ID_W(ID_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .mode      (mode),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .hold_cnt  (hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       mode;
        logic [3:0] gnt;
        logic [7:0] hold;
    } vec_t;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] hold;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state for the random phases (owner -1 = idle).
    int m_owner = -1;
    int m_hold  = 0;
    int m_ptr   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic int idx_of(input logic [3:0] g);
        for (int k = 0; k < N; k++) begin
            if (g[k]) return k;
        end
        return 0;
    endfunction

    function automatic void add_vec(input logic [3:0] r, input logic md,
                                    input logic [3:0] eg, input int eh);
        vec_t v;
        v.req  = r;
        v.mode = md;
        v.gnt  = eg;
        v.hold = 8'(eh);
        vecs.push_back(v);
    endfunction

    // Drive one cycle of stimulus, queue its expected result, compare after the edge.
    task automatic drive(input logic [3:0] r, input logic md, input logic [3:0] eg,
                         input logic [7:0] eh, input string tag);
        exp_t e;
        @(negedge clk);
        req  = r;
        mode = md;
        e.gnt  = eg;
        e.hold = eh;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({tag, ".gnt"},   32'(gnt),       32'(e.gnt));
        chk({tag, ".id"},    32'(gnt_id),    32'(idx_of(e.gnt)));
        chk({tag, ".valid"}, 32'(gnt_valid), 32'(e.gnt != 4'b0));
        chk({tag, ".hold"},  32'(hold_cnt),  32'(e.hold));
    endtask

    task automatic model_step(input logic [3:0] r, input logic md,
                              output logic [3:0] eg, output logic [7:0] eh);
        logic [3:0] cand;
        logic [3:0] own;
        bit         arb;
        int         w;
        int         c;
        arb  = 1'b0;
        cand = r;
        own  = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
        if (m_owner < 0) begin
            arb = (r != 4'b0);
        end else if ((r & own) == 4'b0) begin
            arb = 1'b1;
        end else if (m_hold >= HOLD_MAX - 1 && (r & ~own) != 4'b0) begin
            arb  = 1'b1;
            cand = r & ~own;
        end
        if (arb) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                c = md ? (m_ptr + k) % N : k;
                if (w < 0 && cand[c]) w = c;
            end
            m_hold = 0;
            if (w < 0) begin
                m_owner = -1;
            end else begin
                m_owner = w;
                m_ptr   = (w + 1) % N;
            end
        end else if (m_owner >= 0 && m_hold < 255) begin
            m_hold++;
        end
        eg = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
        eh = 8'(m_hold);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = 4'b0;
        mode  = 1'b0;
        @(negedge clk);
        reset   = 1'b0;
        m_owner = -1;
        m_hold  = 0;
        m_ptr   = 0;
    endtask

    initial begin : main
        logic [3:0] r;
        logic       md;
        logic [3:0] eg;
        logic [7:0] eh;
        int         waitc[N];

        reset = 1'b1;
        req   = 4'b0;
        mode  = 1'b0;

        // Fixed mode: owners drop after 2 cycles -> 1,2,3 back to back.
        add_vec(4'b1110, 0, 4'b0010, 0);
        add_vec(4'b1110, 0, 4'b0010, 1);
        add_vec(4'b1100, 0, 4'b0100, 0);
        add_vec(4'b1100, 0, 4'b0100, 1);
        add_vec(4'b1000, 0, 4'b1000, 0);
        add_vec(4'b1000, 0, 4'b1000, 1);
        add_vec(4'b0000, 0, 4'b0000, 0);
        // Round-robin with all requesting: 0,1,2,3,0, each forced out after 4 cycles.
        for (int o = 0; o < 5; o++) begin
            for (int h = 0; h < HOLD_MAX; h++) begin
                add_vec(4'b1111, 1, 4'(1 << (o % N)), h);
            end
        end
        add_vec(4'b0000, 1, 4'b0000, 0);
        // Starvation guard in fixed mode: ch0 x4, ch1 x4, ch0.
        for (int h = 0; h < HOLD_MAX; h++) add_vec(4'b0011, 0, 4'b0001, h);
        for (int h = 0; h < HOLD_MAX; h++) add_vec(4'b0011, 0, 4'b0010, h);
        add_vec(4'b0011, 0, 4'b0001, 0);
        add_vec(4'b0000, 0, 4'b0000, 0);
        // Lone requester keeps gnt past the limit, then yields at once to a newcomer.
        for (int h = 0; h < 20; h++) add_vec(4'b0001, 0, 4'b0001, h);
        add_vec(4'b0011, 0, 4'b0010, 0);
        add_vec(4'b0000, 0, 4'b0000, 0);
        // Mode toggles mid-grant are ignored; mode at the next arbitration decides.
        add_vec(4'b0010, 1, 4'b0010, 0);
        add_vec(4'b0010, 0, 4'b0010, 1);
        add_vec(4'b0010, 1, 4'b0010, 2);
        add_vec(4'b1001, 0, 4'b0001, 0);
        add_vec(4'b1001, 1, 4'b0001, 1);
        add_vec(4'b0000, 1, 4'b0000, 0);
        // Owner drops req on the same edge its hold limit expires.
        for (int h = 0; h < HOLD_MAX; h++) add_vec(4'b0011, 1, 4'b0010, h);
        add_vec(4'b0101, 1, 4'b0100, 0);
        add_vec(4'b0000, 1, 4'b0000, 0);

        // Reset state while reset is held.
        #12;
        chk("rst.gnt",   32'(gnt),       32'h0);
        chk("rst.valid", 32'(gnt_valid), 32'h0);
        chk("rst.id",    32'(gnt_id),    32'h0);
        chk("rst.hold",  32'(hold_cnt),  32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Reset landing between edges while a grant is held.
        drive(4'b0010, 0, 4'b0010, 8'd0, "mid0");
        drive(4'b0010, 0, 4'b0010, 8'd1, "mid1");
        #2;
        reset = 1'b1;
        req   = 4'b0;
        #1;
        chk("midrst.gnt",   32'(gnt),       32'h0);
        chk("midrst.valid", 32'(gnt_valid), 32'h0);
        chk("midrst.id",    32'(gnt_id),    32'h0);
        chk("midrst.hold",  32'(hold_cnt),  32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(4'b0100, 0, 4'b0100, 8'd0, "post_rst");
        drive(4'b0000, 0, 4'b0000, 8'd0, "post_idle");

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].req, vecs[i].mode, vecs[i].gnt, vecs[i].hold,
                  $sformatf("vec%0d", i));
        end

        // hold_cnt saturation.
        for (int k = 0; k < 260; k++) begin
            drive(4'b0001, 0, 4'b0001, (k > 255) ? 8'd255 : 8'(k), $sformatf("sat%0d", k));
        end
        drive(4'b0000, 0, 4'b0000, 8'd0, "sat_end");

        // Random req/mode, compared against the model plus invariants.
        do_reset();
        r  = 4'b0;
        md = 1'b0;
        for (int it = 0; it < 100; it++) begin
            if ($urandom_range(0, 3) == 0) r  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) md = 1'($urandom_range(0, 1));
            model_step(r, md, eg, eh);
            drive(r, md, eg, eh, $sformatf("rnd%0d", it));
            chk("rnd.onehot", 32'($onehot0(gnt)), 32'd1);
            chk("rnd.valid_cons", 32'(gnt_valid), 32'(gnt != 4'b0));
        end

        // Round-robin fairness: no continuous requester waits beyond the bound.
        do_reset();
        r = 4'b0;
        for (int k = 0; k < N; k++) waitc[k] = 0;
        for (int it = 0; it < 200; it++) begin
            int worst;
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 7) == 0) r[k] = ~r[k];
            end
            model_step(r, 1'b1, eg, eh);
            drive(r, 1'b1, eg, eh, $sformatf("rr%0d", it));
            worst = 0;
            for (int k = 0; k < N; k++) begin
                if (r[k] && !gnt[k]) waitc[k]++;
                else waitc[k] = 0;
                if (waitc[k] > worst) worst = waitc[k];
            end
            chk("rr.wait_bound", 32'(worst > WAIT_MAX), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
